execute_stage_pipe: RTL and testbench
=====================================

Name: execute_stage_pipe

Overview:
Parametrised RV32-style execute stage and EX/MEM pipeline register. It forwards operands from the MEM and WB stages, runs the ALU, resolves branches, JAL and JALR, and raises a redirect to fetch. Results and control are registered into an elastic valid/ready stage so downstream backpressure can stall the pipe. It sits between the decode register and the memory stage.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64; shift amount is B[log2(XLEN)-1:0]
MUL_CYCLES, 4, multiply latency in cycles, must be >=2 (used only with EXEC_MUL_EN)

Ports:
EXECUTE_CLOCK  in  1  single clock; all state updates on its rising edge
EXECUTE_RESET  in  1  synchronous, active-high reset
DR_VALID / EX_READY  in / out  1 / 1  decode-to-execute handshake; a transfer ("fire") happens when both are 1
DR_PC, DR_IMM  in  XLEN each  PC of the instruction; imm already sign-extended and selected by decode
DR_RS1, DR_RS2  in  XLEN each  register-file read data
DR_RS1_ADDR, DR_RS2_ADDR, DR_RD  in  5 each  source and destination register indices
DR_ALU_FUN  in  4  ALU op: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and, 1001 pass A; other codes give 0
DR_ALU_SRCB  in  1  0 selects forwarded rs2, 1 selects DR_IMM
DR_CTRL_FLOW  in  2  00 none, 01 branch, 10 jal, 11 jalr
DR_FUNCT3  in  3  branch condition
DR_IS_MUL  in  1  multiply op
DR_REG_WRITE, DR_MEM_WRITE, DR_MEM_READ2  in  1 each  passed through to the pipeline register
DR_RF_WR_SEL  in  2  passed through to the pipeline register
MEM_FWD_WE, MEM_FWD_RD, MEM_FWD_DATA  in  1/5/XLEN  MEM-stage forwarding source
WB_FWD_WE, WB_FWD_RD, WB_FWD_DATA  in  1/5/XLEN  WB-stage forwarding source
MEM_READY  in  1  downstream stage can accept
EXEC_VALID  out  1  pipeline register holds a valid instruction
EXEC_PC, EXEC_PC_4, EXEC_ALU_RESULT, EXEC_RS2  out  XLEN each  registered PC, PC+4, ALU/multiply result, forwarded rs2
EXEC_RD, EXEC_RF_WR_SEL  out  5 / 2  registered
EXEC_REGWRITE, EXEC_MEMWRITE, EXEC_MEMREAD2  out  1 each  registered
REDIRECT, REDIRECT_PC  out  1 / XLEN  combinational; asserted in the fire cycle

Behaviour:
- Forwarding, per source operand. If MEM_FWD_WE=1, MEM_FWD_RD equals the source address, and that address is non-zero, use MEM_FWD_DATA. Otherwise apply the same test to WB. Otherwise use DR_RSx. MEM wins when both match; address 0 is never forwarded.
- ALU A is forwarded rs1. ALU B is selected by DR_ALU_SRCB. All arithmetic wraps modulo 2^XLEN. slt and sra are signed; sltu is unsigned.
- Branch condition on forwarded operands, by DR_FUNCT3: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 lt unsigned, 111 ge unsigned. 010 and 011 are never taken.
- Redirect target: branch and jal use DR_PC+DR_IMM; jalr uses (rs1+DR_IMM) with bit 0 cleared.
- REDIRECT = fire AND (jal OR jalr OR branch taken). When REDIRECT=0, REDIRECT_PC=0.
- EX_READY = (!EXEC_VALID OR MEM_READY), additionally gated by the multiply FSM (see Optional Feature).
- Pipeline register:
  - On fire, load every EXEC_* output and set EXEC_VALID=1. EXEC_PC_4 = DR_PC+4.
  - If there is no fire and MEM_READY=1, clear EXEC_VALID; data outputs keep their values.
  - If EXEC_VALID=1 and MEM_READY=0, hold all outputs.
  - Fire with MEM_READY=1 in the same cycle: new data replaces the old; no bubble is inserted.
- Reset: EXEC_VALID=0, every EXEC_* output =0, FSM returns to IDLE, multiply counter =0, partial product discarded. EX_READY=1 in the first cycle after reset is released.
- Latency: single-cycle ops appear on EXEC_* one clock after fire.

Optional Feature:
EXEC_MUL_EN.
- Defined:
  - FSM has states IDLE, BUSY, DONE.
  - IDLE -> BUSY when DR_VALID=1, DR_IS_MUL=1 and the output slot is free. On entry, latch the forwarded operands and set cnt=0; EX_READY=0.
  - BUSY increments cnt each cycle and moves to DONE when cnt = MUL_CYCLES-2. EX_READY=0 throughout BUSY.
  - In DONE, EX_READY follows the normal rule. Fire loads EXEC_ALU_RESULT with the low XLEN bits of the signed product of the latched operands, and the FSM returns to IDLE.
  - A multiply therefore completes MUL_CYCLES cycles after it is first presented. Decode must hold its inputs stable until fire.
  - Reset during BUSY or DONE returns the FSM to IDLE and drops the operation.
- Undefined: no FSM. DR_IS_MUL is ignored and the instruction executes the DR_ALU_FUN op in a single cycle.

Test Plan:
- Reset: hold EXECUTE_RESET=1 for 2 cycles with DR_VALID=1 -> EXEC_VALID=0, all EXEC_*=0, REDIRECT=0. After release, EX_READY=1.
- Forwarding priority: DR_RS1_ADDR=3, DR_RS1=5, DR_RS2=7, add; MEM_FWD (rd 3, data 100) and WB_FWD (rd 3, data 200) both active -> EXEC_ALU_RESULT=107. Repeat with rd 0 on both sources and DR_RS1_ADDR=0 -> 12.
- Backpressure: EXEC_VALID=1 and MEM_READY=0 for 3 cycles -> EX_READY=0 and outputs frozen. MEM_READY=1 with a new fire -> next instruction loaded with no bubble.
- Branch: DR_PC=0x100, DR_IMM=0xFFFFFFF0, rs1=0xFFFFFFFF, rs2=1, funct3 100 -> REDIRECT=1, REDIRECT_PC=0xF0. Same operands with funct3 110 -> REDIRECT=0.
- JALR: rs1=0x203, DR_IMM=4 -> REDIRECT_PC=0x206, EXEC_PC_4=DR_PC+4.
- Multiply (EXEC_MUL_EN, MUL_CYCLES=4): rs1=6, rs2=0xFFFFFFFD -> EX_READY=0 for 3 cycles, then EXEC_ALU_RESULT=0xFFFFFFEE. A reset asserted in BUSY -> FSM in IDLE and EXEC_VALID=0.

Source files
------------

// File: rtl/execute_stage_pipe.sv
// Execute stage with operand forwarding, ALU, branch/jump redirect and an elastic EX/MEM register.
// Optional multi-cycle multiply is enabled by defining EXEC_MUL_EN.
module execute_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            EXECUTE_CLOCK,
  input  logic            EXECUTE_RESET,
  input  logic            DR_VALID,
  output logic            EX_READY,
  input  logic [XLEN-1:0] DR_PC,
  input  logic [XLEN-1:0] DR_IMM,
  input  logic [XLEN-1:0] DR_RS1,
  input  logic [XLEN-1:0] DR_RS2,
  input  logic [4:0]      DR_RS1_ADDR,
  input  logic [4:0]      DR_RS2_ADDR,
  input  logic [4:0]      DR_RD,
  input  logic [3:0]      DR_ALU_FUN,
  input  logic            DR_ALU_SRCB,
  input  logic [1:0]      DR_CTRL_FLOW,
  input  logic [2:0]      DR_FUNCT3,
  input  logic            DR_IS_MUL,
  input  logic            DR_REG_WRITE,
  input  logic            DR_MEM_WRITE,
  input  logic            DR_MEM_READ2,
  input  logic [1:0]      DR_RF_WR_SEL,
  input  logic            MEM_FWD_WE,
  input  logic [4:0]      MEM_FWD_RD,
  input  logic [XLEN-1:0] MEM_FWD_DATA,
  input  logic            WB_FWD_WE,
  input  logic [4:0]      WB_FWD_RD,
  input  logic [XLEN-1:0] WB_FWD_DATA,
  input  logic            MEM_READY,
  output logic            EXEC_VALID,
  output logic [XLEN-1:0] EXEC_PC,
  output logic [XLEN-1:0] EXEC_PC_4,
  output logic [XLEN-1:0] EXEC_ALU_RESULT,
  output logic [XLEN-1:0] EXEC_RS2,
  output logic [4:0]      EXEC_RD,
  output logic [1:0]      EXEC_RF_WR_SEL,
  output logic            EXEC_REGWRITE,
  output logic            EXEC_MEMWRITE,
  output logic            EXEC_MEMREAD2,
  output logic            REDIRECT,
  output logic [XLEN-1:0] REDIRECT_PC
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] rs1_f, rs2_f, op_b, alu_out, alu_res, br_tgt, jalr_tgt;
  logic [SHW-1:0]  shamt;
  logic            br_taken, fire, slot_free;

  logic            valid_q;
  logic [XLEN-1:0] pc_q, pc4_q, res_q, rs2_q;
  logic [4:0]      rd_q;
  logic [1:0]      wr_sel_q;
  logic            regwr_q, memwr_q, memrd_q;

  // MEM has priority over WB; x0 is never forwarded.
  always_comb begin
    rs1_f = DR_RS1;
    rs2_f = DR_RS2;
    if (MEM_FWD_WE && MEM_FWD_RD == DR_RS1_ADDR && DR_RS1_ADDR != 5'd0)
      rs1_f = MEM_FWD_DATA;
    else if (WB_FWD_WE && WB_FWD_RD == DR_RS1_ADDR && DR_RS1_ADDR != 5'd0)
      rs1_f = WB_FWD_DATA;
    if (MEM_FWD_WE && MEM_FWD_RD == DR_RS2_ADDR && DR_RS2_ADDR != 5'd0)
      rs2_f = MEM_FWD_DATA;
    else if (WB_FWD_WE && WB_FWD_RD == DR_RS2_ADDR && DR_RS2_ADDR != 5'd0)
      rs2_f = WB_FWD_DATA;
  end

  assign op_b  = DR_ALU_SRCB ? DR_IMM : rs2_f;
  assign shamt = op_b[SHW-1:0];

  always_comb begin
    alu_out = '0;
    case (DR_ALU_FUN)
      4'b0000: alu_out = rs1_f + op_b;
      4'b1000: alu_out = rs1_f - op_b;
      4'b0001: alu_out = rs1_f << shamt;
      4'b0010: alu_out = {{(XLEN-1){1'b0}}, ($signed(rs1_f) < $signed(op_b))};
      4'b0011: alu_out = {{(XLEN-1){1'b0}}, (rs1_f < op_b)};
      4'b0100: alu_out = rs1_f ^ op_b;
      4'b0101: alu_out = rs1_f >> shamt;
      4'b1101: alu_out = XLEN'($signed(rs1_f) >>> shamt);
      4'b0110: alu_out = rs1_f | op_b;
      4'b0111: alu_out = rs1_f & op_b;
      4'b1001: alu_out = rs1_f;
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (DR_FUNCT3)
      3'b000: br_taken = (rs1_f == rs2_f);
      3'b001: br_taken = (rs1_f != rs2_f);
      3'b100: br_taken = ($signed(rs1_f) <  $signed(rs2_f));
      3'b101: br_taken = ($signed(rs1_f) >= $signed(rs2_f));
      3'b110: br_taken = (rs1_f <  rs2_f);
      3'b111: br_taken = (rs1_f >= rs2_f);
      default: br_taken = 1'b0;
    endcase
  end

  assign br_tgt   = DR_PC + DR_IMM;
  assign jalr_tgt = (rs1_f + DR_IMM) & ~{{(XLEN-1){1'b0}}, 1'b1};

  assign slot_free = ~valid_q | MEM_READY;
  assign fire      = DR_VALID & EX_READY;

  always_comb begin
    REDIRECT    = 1'b0;
    REDIRECT_PC = '0;
    if (fire && (DR_CTRL_FLOW[1] || (DR_CTRL_FLOW == 2'b01 && br_taken))) begin
      REDIRECT    = 1'b1;
      REDIRECT_PC = (DR_CTRL_FLOW == 2'b11) ? jalr_tgt : br_tgt;
    end
  end

`ifdef EXEC_MUL_EN
  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  mul_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_lo;
  logic            mul_stall;

  // Low XLEN bits of a product are identical for signed and unsigned operands.
  assign mul_lo = mul_a_q * mul_b_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_stall = 1'b0;
    case (state_q)
      IDLE: if (DR_VALID && DR_IS_MUL) begin
        mul_stall = 1'b1;
        if (slot_free) begin
          state_d = BUSY;
          cnt_d   = '0;
          mul_a_d = rs1_f;
          mul_b_d = rs2_f;
        end
      end
      BUSY: begin
        mul_stall = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_d >= CNT_W'(MUL_CYCLES - 2)) state_d = DONE;
      end
      DONE: if (fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge EXECUTE_CLOCK) begin
    if (EXECUTE_RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  assign EX_READY = slot_free & ~mul_stall & ~EXECUTE_RESET;
  assign alu_res  = (state_q == DONE) ? mul_lo : alu_out;
`else
  logic unused_mul;
  assign unused_mul = DR_IS_MUL ^ (MUL_CYCLES == 0);
  assign EX_READY   = slot_free & ~EXECUTE_RESET;
  assign alu_res    = alu_out;
`endif

  // Data fields are only written on fire, so a drain leaves them intact.
  always_ff @(posedge EXECUTE_CLOCK) begin
    if (EXECUTE_RESET) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      pc4_q    <= '0;
      res_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      wr_sel_q <= '0;
      regwr_q  <= 1'b0;
      memwr_q  <= 1'b0;
      memrd_q  <= 1'b0;
    end else if (fire) begin
      valid_q  <= 1'b1;
      pc_q     <= DR_PC;
      pc4_q    <= DR_PC + XLEN'(4);
      res_q    <= alu_res;
      rs2_q    <= rs2_f;
      rd_q     <= DR_RD;
      wr_sel_q <= DR_RF_WR_SEL;
      regwr_q  <= DR_REG_WRITE;
      memwr_q  <= DR_MEM_WRITE;
      memrd_q  <= DR_MEM_READ2;
    end else if (MEM_READY) begin
      valid_q  <= 1'b0;
    end
  end

  assign EXEC_VALID      = valid_q;
  assign EXEC_PC         = pc_q;
  assign EXEC_PC_4       = pc4_q;
  assign EXEC_ALU_RESULT = res_q;
  assign EXEC_RS2        = rs2_q;
  assign EXEC_RD         = rd_q;
  assign EXEC_RF_WR_SEL  = wr_sel_q;
  assign EXEC_REGWRITE   = regwr_q;
  assign EXEC_MEMWRITE   = memwr_q;
  assign EXEC_MEMREAD2   = memrd_q;

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Directed scoreboard bench for execute_stage_pipe (XLEN=32); multiply steps build only with EXEC_MUL_EN.
module tb_execute_stage_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        dr_valid, ex_ready;
  logic [31:0] dr_pc, dr_imm, dr_rs1, dr_rs2;
  logic [4:0]  dr_rs1_addr, dr_rs2_addr, dr_rd;
  logic [3:0]  dr_alu_fun;
  logic        dr_alu_srcb;
  logic [1:0]  dr_ctrl_flow;
  logic [2:0]  dr_funct3;
  logic        dr_is_mul, dr_reg_write, dr_mem_write, dr_mem_read2;
  logic [1:0]  dr_rf_wr_sel;
  logic        mem_fwd_we, wb_fwd_we, mem_ready;
  logic [4:0]  mem_fwd_rd, wb_fwd_rd;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        exec_valid, exec_regwrite, exec_memwrite, exec_memread2, redirect;
  logic [31:0] exec_pc, exec_pc_4, exec_alu_result, exec_rs2, redirect_pc;
  logic [4:0]  exec_rd;
  logic [1:0]  exec_rf_wr_sel;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  execute_stage_pipe #(.XLEN(32), .MUL_CYCLES(4)) dut (
    .EXECUTE_CLOCK(clk), .EXECUTE_RESET(rst),
    .DR_VALID(dr_valid), .EX_READY(ex_ready),
    .DR_PC(dr_pc), .DR_IMM(dr_imm), .DR_RS1(dr_rs1), .DR_RS2(dr_rs2),
    .DR_RS1_ADDR(dr_rs1_addr), .DR_RS2_ADDR(dr_rs2_addr), .DR_RD(dr_rd),
    .DR_ALU_FUN(dr_alu_fun), .DR_ALU_SRCB(dr_alu_srcb), .DR_CTRL_FLOW(dr_ctrl_flow),
    .DR_FUNCT3(dr_funct3), .DR_IS_MUL(dr_is_mul), .DR_REG_WRITE(dr_reg_write),
    .DR_MEM_WRITE(dr_mem_write), .DR_MEM_READ2(dr_mem_read2), .DR_RF_WR_SEL(dr_rf_wr_sel),
    .MEM_FWD_WE(mem_fwd_we), .MEM_FWD_RD(mem_fwd_rd), .MEM_FWD_DATA(mem_fwd_data),
    .WB_FWD_WE(wb_fwd_we), .WB_FWD_RD(wb_fwd_rd), .WB_FWD_DATA(wb_fwd_data),
    .MEM_READY(mem_ready),
    .EXEC_VALID(exec_valid), .EXEC_PC(exec_pc), .EXEC_PC_4(exec_pc_4),
    .EXEC_ALU_RESULT(exec_alu_result), .EXEC_RS2(exec_rs2), .EXEC_RD(exec_rd),
    .EXEC_RF_WR_SEL(exec_rf_wr_sel), .EXEC_REGWRITE(exec_regwrite),
    .EXEC_MEMWRITE(exec_memwrite), .EXEC_MEMREAD2(exec_memread2),
    .REDIRECT(redirect), .REDIRECT_PC(redirect_pc)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh  = int'(b[4:0]);
    ext = {{32{a[31]}}, a};
    case (f)
      4'd0:    return a + b;
      4'd8:    return a + ~b + 32'd1;
      4'd1:    return a << sh;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a ^ b;
      4'd5:    return a >> sh;
      4'd13:   begin ext = ext >> sh; return ext[31:0]; end
      4'd6:    return a | b;
      4'd7:    return a & b;
      4'd9:    return a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_idle();
    dr_valid = 0; dr_pc = 0; dr_imm = 0; dr_rs1 = 0; dr_rs2 = 0;
    dr_rs1_addr = 5'd1; dr_rs2_addr = 5'd2; dr_rd = 0; dr_alu_fun = 0;
    dr_alu_srcb = 0; dr_ctrl_flow = 0; dr_funct3 = 3'b010; dr_is_mul = 0;
    dr_reg_write = 0; dr_mem_write = 0; dr_mem_read2 = 0; dr_rf_wr_sel = 0;
    mem_fwd_we = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
    wb_fwd_we = 0; wb_fwd_rd = 0; wb_fwd_data = 0; mem_ready = 1;
  endtask

  // Called at posedge+1 with inputs driven; expects a fire this cycle.
  task automatic fire_check(input string tag, input logic [31:0] exp_alu,
                            input logic exp_redir, input logic [31:0] exp_rpc);
    exp_t e;
    #1;
    chk({tag, "_ready"}, ex_ready, 1);
    chk({tag, "_redirect"}, redirect, exp_redir);
    chk({tag, "_redirect_pc"}, redirect_pc, exp_rpc);
    sb.push_back('{alu: exp_alu, pc4: dr_pc + 32'd4, rd: dr_rd});
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, "_valid"}, exec_valid, 1);
    chk({tag, "_alu"}, exec_alu_result, e.alu);
    chk({tag, "_pc4"}, exec_pc_4, e.pc4);
    chk({tag, "_rd"}, exec_rd, e.rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [12];
    ops = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7, 4'd9, 4'd10};

    // reset held with a valid jal presented
    set_idle();
    rst = 1; dr_valid = 1; dr_ctrl_flow = 2'b10; dr_pc = 32'h40; dr_imm = 32'h8;
    @(posedge clk); #1;
    chk("rst_redirect", redirect, 0);
    @(posedge clk); #1;
    chk("rst_valid", exec_valid, 0);
    chk("rst_pc", exec_pc, 0);
    chk("rst_alu", exec_alu_result, 0);
    chk("rst_rd", exec_rd, 0);
    chk("rst_redirect2", redirect, 0);
    rst = 0; set_idle();
    #1 chk("rst_release_ready", ex_ready, 1);
    @(posedge clk); #1;

    // forwarding priority
    set_idle(); dr_valid = 1;
    dr_rs1_addr = 3; dr_rs2_addr = 4; dr_rs1 = 5; dr_rs2 = 7; dr_rd = 9;
    mem_fwd_we = 1; mem_fwd_rd = 3; mem_fwd_data = 100;
    wb_fwd_we = 1;  wb_fwd_rd = 3;  wb_fwd_data = 200;
    fire_check("fwd_mem_prio", 32'd107, 0, 0);
    mem_fwd_we = 0;
    fire_check("fwd_wb", 32'd207, 0, 0);
    mem_fwd_we = 1; mem_fwd_rd = 0; wb_fwd_rd = 0; dr_rs1_addr = 0;
    fire_check("fwd_x0", 32'd12, 0, 0);
    dr_rs1_addr = 3; mem_fwd_rd = 4; mem_fwd_data = 50; wb_fwd_we = 0; dr_alu_fun = 4'd8;
    fire_check("fwd_rs2_sub", 32'hFFFF_FFD3, 0, 0);
    chk("fwd_rs2_out", exec_rs2, 50);

    // ALU sweep, forwarding off
    for (int i = 0; i < 12; i++) begin
      set_idle(); dr_valid = 1;
      dr_alu_fun = ops[i]; dr_rs1 = $urandom; dr_rs2 = $urandom; dr_imm = $urandom;
      dr_alu_srcb = 1'($urandom_range(0, 1)); dr_rd = 5'($urandom_range(1, 31));
      dr_pc = $urandom & 32'hFFFF_FFFC;
      if (i == 7) dr_rs1[31] = 1'b1;
      fire_check($sformatf("alu_op%0d", ops[i]),
                 alu_model(ops[i], dr_rs1, dr_alu_srcb ? dr_imm : dr_rs2), 0, 0);
    end

    // backpressure
    set_idle();
    @(posedge clk); #1;
    chk("bp_drained", exec_valid, 0);
    dr_valid = 1; dr_rs1 = 1; dr_rs2 = 2; dr_rd = 5; mem_ready = 0;
    fire_check("bp_a", 32'd3, 0, 0);
    dr_rs1 = 10; dr_rs2 = 20; dr_rd = 6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_stall_ready%0d", i), ex_ready, 0);
      chk($sformatf("bp_hold_alu%0d", i), exec_alu_result, 3);
      chk($sformatf("bp_hold_valid%0d", i), exec_valid, 1);
      @(posedge clk); #1;
    end
    mem_ready = 1;
    fire_check("bp_b", 32'd30, 0, 0);
    dr_valid = 0;
    @(posedge clk); #1;
    chk("bp_drain_valid", exec_valid, 0);
    chk("bp_drain_keep", exec_alu_result, 30);

    // branches
    set_idle(); dr_valid = 1; dr_ctrl_flow = 2'b01; dr_alu_fun = 4'd8;
    dr_pc = 32'h100; dr_imm = 32'hFFFF_FFF0; dr_rs1 = 32'hFFFF_FFFF; dr_rs2 = 1;
    dr_funct3 = 3'b100;
    fire_check("br_blt", 32'hFFFF_FFFE, 1, 32'hF0);
    dr_funct3 = 3'b110;
    fire_check("br_bltu", 32'hFFFF_FFFE, 0, 0);
    dr_funct3 = 3'b000; dr_rs1 = 9; dr_rs2 = 9;
    fire_check("br_beq", 32'd0, 1, 32'hF0);
    dr_funct3 = 3'b011; dr_rs1 = 0; dr_rs2 = 1;
    fire_check("br_f3_011", 32'hFFFF_FFFF, 0, 0);

    // jumps
    set_idle(); dr_valid = 1; dr_ctrl_flow = 2'b11; dr_alu_srcb = 1;
    dr_pc = 32'h400; dr_rs1 = 32'h203; dr_imm = 4;
    fire_check("jalr", 32'h207, 1, 32'h206);
    chk("jalr_pc", exec_pc, 32'h400);
    dr_rs1_addr = 5; mem_fwd_we = 1; mem_fwd_rd = 5; mem_fwd_data = 32'h301;
    fire_check("jalr_fwd", 32'h305, 1, 32'h304);
    set_idle(); dr_valid = 1; dr_ctrl_flow = 2'b10; dr_alu_fun = 4'd9;
    dr_pc = 32'h1000; dr_imm = 32'h20; dr_rs1 = 32'h55;
    fire_check("jal", 32'h55, 1, 32'h1020);

    // reset with a valid instruction in the register
    rst = 1; #1;
    chk("rst2_redirect", redirect, 0);
    @(posedge clk); #1;
    chk("rst2_valid", exec_valid, 0);
    chk("rst2_pc4", exec_pc_4, 0);
    rst = 0; set_idle();
    @(posedge clk); #1;

`ifdef EXEC_MUL_EN
    begin
      int stalls = 0;
      exp_t e;
      set_idle(); dr_valid = 1; dr_is_mul = 1; dr_rs1 = 6; dr_rs2 = 32'hFFFF_FFFD; dr_rd = 7;
      for (int g = 0; g < 20; g++) begin
        #1;
        if (ex_ready) break;
        stalls++;
        @(posedge clk);
      end
      chk("mul_stalls", 64'(stalls), 3);
      sb.push_back('{alu: 32'hFFFF_FFEE, pc4: dr_pc + 32'd4, rd: dr_rd});
      @(posedge clk); #1;
      e = sb.pop_front();
      chk("mul_valid", exec_valid, 1);
      chk("mul_result", exec_alu_result, e.alu);
      chk("mul_rd", exec_rd, e.rd);
      set_idle(); dr_valid = 1; dr_is_mul = 1; dr_rs1 = 3; dr_rs2 = 3;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1;
      @(posedge clk); #1;
      chk("mul_rst_valid", exec_valid, 0);
      rst = 0; set_idle();
      #1 chk("mul_rst_ready", ex_ready, 1);
      @(posedge clk); #1;
      set_idle(); dr_valid = 1; dr_rs1 = 4; dr_rs2 = 5;
      fire_check("mul_after_rst_add", 32'd9, 0, 0);
    end
`else
    set_idle(); dr_valid = 1; dr_is_mul = 1; dr_rs1 = 6; dr_rs2 = 32'hFFFF_FFFD;
    fire_check("mul_ignored", 32'd3, 0, 0);
`endif

    set_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
